down_counter_timer: RTL

DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

---
 rtl/down_counter_timer_if.sv | 32 +++
 rtl/down_counter_timer.sv | 94 +++++++++
 2 files changed

// File: rtl/down_counter_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : down_counter_timer_if
// Brief    : Control and status bundle for down_counter_timer. The master
//            drives the controls and the slave (the timer) returns the status.
// Revision : 1.0 - initial release
// ============================================================================
interface down_counter_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] d;
    logic             start;
    logic             stop;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             tc;

    modport master (
        output load, d, start, stop, en, auto_reload,
        input  q, busy, done, tc
    );

    modport slave (
        input  load, d, start, stop, en, auto_reload,
        output q, busy, done, tc
    );
endinterface
`default_nettype wire

// File: rtl/down_counter_timer.sv
`default_nettype none
// ============================================================================
// Module   : down_counter_timer
// Brief    : Loadable down counter with start/stop control, a count enable
//            (prescaler tick), optional auto-reload and a one-cycle
//            terminal-count pulse.
// Revision : 1.0 - initial release
// ============================================================================
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  wire logic            clk,
    input  wire logic            reset,
    down_counter_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] r_rl;
    logic [WIDTH-1:0] w_rl_next;
    logic             r_tc;
    logic             w_tc_next;

    // State, count, reload and tc registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_rl    <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_rl    <= w_rl_next;
            r_tc    <= w_tc_next;
        end
    end

    // Next-state decode in priority order: load > stop > start > count.
    // An active start in RUN is a no-op but still outranks the count.
    always_comb begin
        w_state_next = r_state;
        w_q_next     = r_q;
        w_rl_next    = r_rl;
        w_tc_next    = 1'b0;

        if (bus.load) begin
            w_q_next  = bus.d;
            w_rl_next = bus.d;
            // Only a nonzero reload keeps a running timer running.
            if ((r_state == RUN) && (bus.d != '0)) begin
                w_state_next = RUN;
            end else begin
                w_state_next = IDLE;
            end
        end else if (bus.stop) begin
            if (r_state == RUN) begin
                w_state_next = IDLE;
            end
        end else if (bus.start) begin
            // Never enter RUN with a zero count, so q cannot underflow.
            if ((r_state != RUN) && (r_q != '0)) begin
                w_state_next = RUN;
            end
        end else if ((r_state == RUN) && bus.en) begin
            if (r_q == WIDTH'(1)) begin
                w_tc_next = 1'b1;
                if (bus.auto_reload && (r_rl != '0)) begin
                    w_q_next = r_rl;
                end else begin
                    w_q_next     = '0;
                    w_state_next = DONE;
                end
            end else begin
                w_q_next = r_q - WIDTH'(1);
            end
        end
    end

    assign bus.q    = r_q;
    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
    assign bus.tc   = r_tc;

endmodule
`default_nettype wire
